// File: rtl/gnrl_iq_boxcar_decim_pkg.sv
// Shared types and width helpers for the I/Q boxcar decimator.
package gnrl_iq_boxcar_decim_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    localparam int unsigned OVR_CNT_W = 16;

    // Accumulator width: sample width plus enough headroom for 2^len_w-1 samples.
    function automatic int unsigned acc_width(input int unsigned adc_phys_w,
                                              input int unsigned len_w);
        return adc_phys_w + 1 + len_w;
    endfunction

endpackage

// File: rtl/gnrl_iq_out_reg.sv
// Valid/ready holding register for a decimated I/Q pair; drops and flags
// a new sum that arrives while the previous one is still unconsumed.
module gnrl_iq_out_reg
    import gnrl_iq_boxcar_decim_pkg::*;
#(
    parameter int unsigned W = 25
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 load,
    input  logic signed [W-1:0]  sum_i,
    input  logic signed [W-1:0]  sum_q,
    input  logic                 out_ready,
    input  logic                 ovr_clr,
    output logic signed [W-1:0]  out_i,
    output logic signed [W-1:0]  out_q,
    output logic                 out_valid,
    output logic                 overrun,
    output logic [OVR_CNT_W-1:0] ovr_cnt
);

    logic handshake;
    logic drop;

    assign handshake = out_valid && out_ready;
    assign drop      = load && out_valid && !out_ready;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out_i     <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            ovr_cnt   <= '0;
        end else begin
            if (load && !drop) begin
                out_i     <= sum_i;
                out_q     <= sum_q;
                out_valid <= 1'b1;
            end else if (handshake) begin
                out_valid <= 1'b0;
            end

            // A drop in the same cycle as a clear restarts the count at one.
            if (drop) begin
                overrun <= 1'b1;
                if (ovr_clr)
                    ovr_cnt <= OVR_CNT_W'(1);
                else if (ovr_cnt != {OVR_CNT_W{1'b1}})
                    ovr_cnt <= ovr_cnt + OVR_CNT_W'(1);
            end else if (ovr_clr) begin
                overrun <= 1'b0;
                ovr_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/gnrl_iq_boxcar_decim.sv
// Boxcar integrate-and-dump decimator for the signed I/Q stream from the
// dconv stage; one summed pair per decim_len accepted samples.
module gnrl_iq_boxcar_decim
    import gnrl_iq_boxcar_decim_pkg::*;
#(
    parameter int unsigned ADC_PHYS_WIDTH = 14,
    parameter int unsigned LEN_W          = 10,
    parameter int unsigned EN_DELAY       = 2
) (
    input  logic                                       CLK,
    input  logic                                       RESET,
    input  logic signed [ADC_PHYS_WIDTH:0]             data_i,
    input  logic signed [ADC_PHYS_WIDTH:0]             data_q,
    input  logic                                       conv_en,
    input  logic [LEN_W-1:0]                           decim_len,
    output logic signed [acc_width(ADC_PHYS_WIDTH, LEN_W)-1:0] out_i,
    output logic signed [acc_width(ADC_PHYS_WIDTH, LEN_W)-1:0] out_q,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    input  logic                                       ovr_clr,
    output logic                                       overrun,
    output logic [OVR_CNT_W-1:0]                       ovr_cnt
);

    localparam int unsigned ACC_W = acc_width(ADC_PHYS_WIDTH, LEN_W);

    logic [EN_DELAY-1:0]      en_pipe;
    logic                     en_d;

    state_t                   state, state_nxt;
    logic [LEN_W-1:0]         len, len_nxt;
    logic [LEN_W-1:0]         cnt, cnt_nxt;
    logic signed [ACC_W-1:0]  acc_i, acc_i_nxt;
    logic signed [ACC_W-1:0]  acc_q, acc_q_nxt;

    logic [LEN_W-1:0]         len_eff;
    logic [LEN_W-1:0]         cnt_inc;
    logic signed [ACC_W-1:0]  samp_i, samp_q;
    logic signed [ACC_W-1:0]  sum_i, sum_q;
    logic                     win_done;

    // Align conv_en with the samples leaving the dconv pipeline.
    generate
        if (EN_DELAY == 1) begin : g_en_one
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) en_pipe <= '0;
                else       en_pipe <= conv_en;
            end
        end else begin : g_en_multi
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) en_pipe <= '0;
                else       en_pipe <= {en_pipe[EN_DELAY-2:0], conv_en};
            end
        end
    endgenerate

    assign en_d    = en_pipe[EN_DELAY-1];
    assign len_eff = (decim_len == '0) ? LEN_W'(1) : decim_len;
    assign cnt_inc = LEN_W'(cnt + LEN_W'(1));
    assign samp_i  = ACC_W'(data_i);
    assign samp_q  = ACC_W'(data_q);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
            len   <= '0;
            cnt   <= '0;
            acc_i <= '0;
            acc_q <= '0;
        end else begin
            state <= state_nxt;
            len   <= len_nxt;
            cnt   <= cnt_nxt;
            acc_i <= acc_i_nxt;
            acc_q <= acc_q_nxt;
        end
    end

    // Window sequencing; a completing window returns to IDLE so the very next
    // accepted sample opens a fresh window without a gap.
    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        cnt_nxt   = cnt;
        acc_i_nxt = acc_i;
        acc_q_nxt = acc_q;
        sum_i     = acc_i + samp_i;
        sum_q     = acc_q + samp_q;
        win_done  = 1'b0;

        case (state)
            ST_IDLE: begin
                sum_i = samp_i;
                sum_q = samp_q;
                if (en_d) begin
                    len_nxt   = len_eff;
                    cnt_nxt   = LEN_W'(1);
                    acc_i_nxt = samp_i;
                    acc_q_nxt = samp_q;
                    if (len_eff == LEN_W'(1))
                        win_done = 1'b1;
                    else
                        state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (en_d) begin
                    acc_i_nxt = sum_i;
                    acc_q_nxt = sum_q;
                    cnt_nxt   = cnt_inc;
                    if (cnt_inc == len) begin
                        win_done  = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    gnrl_iq_out_reg #(
        .W (ACC_W)
    ) u_out_reg (
        .CLK       (CLK),
        .RESET     (RESET),
        .load      (win_done),
        .sum_i     (sum_i),
        .sum_q     (sum_q),
        .out_ready (out_ready),
        .ovr_clr   (ovr_clr),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_valid (out_valid),
        .overrun   (overrun),
        .ovr_cnt   (ovr_cnt)
    );

endmodule

// File: tb/tb_gnrl_iq_boxcar_decim.sv
// Randomized self-checking bench for gnrl_iq_boxcar_decim against a
// queue-based window-sum reference model.
module tb_gnrl_iq_boxcar_decim;

    localparam int unsigned ADC = 14;
    localparam int unsigned LW  = 10;
    localparam int unsigned ED  = 2;
    localparam int unsigned AW  = ADC + 1 + LW;

    logic                 CLK = 1'b0;
    logic                 RESET;
    logic signed [ADC:0]  data_i, data_q;
    logic                 conv_en;
    logic [LW-1:0]        decim_len;
    logic signed [AW-1:0] out_i, out_q;
    logic                 out_valid;
    logic                 out_ready;
    logic                 ovr_clr;
    logic                 overrun;
    logic [15:0]          ovr_cnt;

    always #5 CLK = ~CLK;

    gnrl_iq_boxcar_decim #(
        .ADC_PHYS_WIDTH (ADC),
        .LEN_W          (LW),
        .EN_DELAY       (ED)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .data_i    (data_i),
        .data_q    (data_q),
        .conv_en   (conv_en),
        .decim_len (decim_len),
        .out_i     (out_i),
        .out_q     (out_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovr_clr   (ovr_clr),
        .overrun   (overrun),
        .ovr_cnt   (ovr_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit                   en_hist [ED];
    int                   win_i [$];
    int                   win_q [$];
    int                   win_len;
    logic                 m_valid;
    logic signed [AW-1:0] m_i, m_q;
    logic                 m_ovr;
    int                   m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (en_hist[k]) en_hist[k] = 1'b0;
        win_i.delete();
        win_q.delete();
        win_len = 0;
        m_valid = 1'b0;
        m_i     = '0;
        m_q     = '0;
        m_ovr   = 1'b0;
        m_cnt   = 0;
    endtask

    // Advance the model across one rising edge using the currently driven inputs.
    task automatic model_edge();
        bit en_now, done, hs, drop;
        int si, sq;
        en_now = en_hist[ED-1];
        hs     = m_valid && out_ready;
        done   = 1'b0;
        si     = 0;
        sq     = 0;
        if (en_now) begin
            if (win_i.size() == 0)
                win_len = (decim_len == 0) ? 1 : int'(decim_len);
            win_i.push_back(int'(data_i));
            win_q.push_back(int'(data_q));
            if (win_i.size() == win_len) begin
                done = 1'b1;
                foreach (win_i[k]) si += win_i[k];
                foreach (win_q[k]) sq += win_q[k];
                win_i.delete();
                win_q.delete();
            end
        end else begin
            win_i.delete();
            win_q.delete();
        end
        drop = done && m_valid && !out_ready;
        if (done && !drop) begin
            m_i     = AW'(si);
            m_q     = AW'(sq);
            m_valid = 1'b1;
        end else if (hs) begin
            m_valid = 1'b0;
        end
        if (drop) begin
            m_ovr = 1'b1;
            m_cnt = ovr_clr ? 1 : ((m_cnt == 65535) ? 65535 : m_cnt + 1);
        end else if (ovr_clr) begin
            m_ovr = 1'b0;
            m_cnt = 0;
        end
        for (int k = ED - 1; k > 0; k--) en_hist[k] = en_hist[k-1];
        en_hist[0] = conv_en;
    endtask

    // Compare current outputs, drive the next cycle's inputs, advance one cycle.
    task automatic step(input logic rst, input logic en, input logic [LW-1:0] len,
                        input logic signed [ADC:0] di, input logic signed [ADC:0] dq,
                        input logic rdy, input logic clr);
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_i",     32'(out_i),     32'(m_i));
        check("out_q",     32'(out_q),     32'(m_q));
        check("overrun",   32'(overrun),   32'(m_ovr));
        check("ovr_cnt",   32'(ovr_cnt),   32'(m_cnt));
        RESET     = rst;
        conv_en   = en;
        decim_len = len;
        data_i    = di;
        data_q    = dq;
        out_ready = rdy;
        ovr_clr   = clr;
        if (rst) model_reset();
        else     model_edge();
        @(negedge CLK);
    endtask

    task automatic flush(input logic [LW-1:0] len);
        repeat (ED + 3) step(1'b0, 1'b0, len, '0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        int first_valid;
        int seen;
        RESET = 1'b1; conv_en = 1'b0; decim_len = '0;
        data_i = '0; data_q = '0; out_ready = 1'b0; ovr_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK);
        step(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0);
        flush(10'd4);

        // Constant +100/-100, window 4, first pair EN_DELAY+4 cycles after enable
        first_valid = -1;
        seen = 0;
        for (int k = 0; k < 24; k++) begin
            if (out_valid && first_valid < 0) first_valid = k;
            if (out_valid) begin
                seen++;
                check("len4_out_i", 32'(out_i), 32'(400));
                check("len4_out_q", 32'(out_q), 32'(-400));
            end
            step(1'b0, 1'b1, 10'd4, 15'sd100, -15'sd100, 1'b1, 1'b0);
        end
        check("len4_latency", 32'(first_valid), 32'(ED + 4));
        check("len4_count", 32'(seen), 32'(5));
        flush(10'd0);

        // Window length 0 behaves as pass-through
        for (int k = 0; k < 12; k++)
            step(1'b0, 1'b1, 10'd0, 15'(k + 1), 15'(-k), 1'b1, 1'b0);
        flush(10'd1023);

        // Maximum window of most-negative samples must not wrap
        seen = 0;
        for (int k = 0; k < 1023 + ED + 4; k++) begin
            if (out_valid) begin
                seen++;
                check("len1023_sum", 32'(out_i), 32'(-16760832));
            end
            step(1'b0, (k < 1023), 10'd1023, -15'sd16384, -15'sd16384, 1'b1, 1'b0);
        end
        check("len1023_seen", 32'(seen), 32'(1));
        flush(10'd4);

        // Back-pressure: first sum held, two later windows dropped
        for (int k = 0; k < 16; k++)
            step(1'b0, (k < 12), 10'd4, 15'sd100, -15'sd100, 1'b0, 1'b0);
        check("ovr_flag", 32'(overrun), 32'(1));
        check("ovr_count", 32'(ovr_cnt), 32'(2));
        check("ovr_held_i", 32'(out_i), 32'(400));
        step(1'b0, 1'b0, 10'd4, '0, '0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 10'd4, '0, '0, 1'b1, 1'b0);
        check("ovr_clr_flag", 32'(overrun), 32'(0));
        check("ovr_clr_count", 32'(ovr_cnt), 32'(0));
        flush(10'd8);

        // Partial window abandoned, then a clean 8-sample window
        seen = 0;
        for (int k = 0; k < 24; k++) begin
            if (out_valid) seen++;
            step(1'b0, (k < 3) || (k >= 7 && k < 15), 10'd8,
                 15'($urandom), 15'($urandom), 1'b1, 1'b0);
        end
        check("partial_outputs", 32'(seen), 32'(1));
        flush(10'd8);

        // Reset in the middle of a window
        for (int k = 0; k < 7; k++)
            step(1'b0, 1'b1, 10'd8, 15'($urandom), 15'($urandom), 1'b1, 1'b0);
        step(1'b1, 1'b1, 10'd8, '0, '0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 10'd8, '0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 24; k++)
            step(1'b0, 1'b1, 10'd8, 15'($urandom), 15'($urandom), 1'b1, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++)
            step(1'b0, ($urandom_range(0, 9) != 0), 10'($urandom_range(0, 7)),
                 15'($urandom), 15'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 40) == 0));
        step(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
